// File: rtl/mips_cpu_control_seq.sv
// Sequenced MIPS control unit: decodes op/funct/dest into datapath controls
// and runs a small FSM for memory waits, SB/SH read-modify-write and the
// MULT/MULTU/DIV/DIVU busy period.
// Optional feature: define UNALIGNED_TRAP_EN to trap misaligned LW/SW/LH/LHU/SH
// in DECODE (access suppressed, err set).
//
// Handshake: instr_valid marks op/funct/dest as a new instruction and is only
// looked at in DECODE. mem_waitrequest high means the memory did not accept
// the current access; the access (and its controls) is held until a cycle
// with mem_waitrequest low. stall high tells the CPU to hold PC/IR this cycle.
module mips_cpu_control_seq #(
  parameter int MULDIV_CYCLES = 32,
  parameter int MEM_WAIT_MAX  = 15,
  parameter int STATE_W       = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic [4:0]         dest,
  input  logic [1:0]         addr_lo,
  input  logic               mem_waitrequest,
  output logic               regwrite,
  output logic               regdst2,
  output logic               regdst1,
  output logic               alusrc,
  output logic               branch,
  output logic               data_read,
  output logic               data_write,
  output logic               memtoreg1,
  output logic               jump1,
  output logic               jump,
  output logic [1:0]         aluop,
  output logic [2:0]         loadcontrol,
  output logic [3:0]         byteenable,
  output logic               stall,
  output logic               err,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [2:0] {
    ST_DECODE   = 3'd0,
    ST_MEM_WAIT = 3'd1,
    ST_RMW_RD   = 3'd2,
    ST_RMW_WR   = 3'd3,
    ST_MULDIV   = 3'd4
  } state_t;

  typedef struct packed {
    logic       regwrite;
    logic       regdst2;
    logic       regdst1;
    logic       alusrc;
    logic       branch;
    logic       data_read;
    logic       data_write;
    logic       memtoreg1;
    logic       jump1;
    logic       jump;
    logic [1:0] aluop;
    logic [2:0] loadcontrol;
    logic [3:0] byteenable;
  } ctrl_t;

  localparam logic [7:0] MD_LOAD   = 8'(MULDIV_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  state_t     cur;
  ctrl_t      held;      // controls driven in every non-DECODE state
  ctrl_t      dec;       // combinational decode of the current fields
  ctrl_t      wr_ctrl;   // controls for the RMW write phase
  ctrl_t      out;
  logic [7:0] wait_cnt;
  logic [7:0] md_cnt;
  logic [3:0] lat_be;    // RMW byte lanes, captured with addr_lo at decode
  logic [3:0] rmw_be_dec;
  logic       is_mem;
  logic       is_rmw;
  logic       is_muldiv;
  logic       trap;
  logic       wait_last;

  assign wait_last = (wait_cnt == WAIT_LAST);

`ifdef UNALIGNED_TRAP_EN
  assign trap = (((op == 6'b100011) || (op == 6'b101011)) && (addr_lo != 2'b00)) ||
                (((op == 6'b100001) || (op == 6'b100101) || (op == 6'b101001)) && addr_lo[0]);
`else
  assign trap = 1'b0;
`endif

  // Main decode: instruction fields to controls and instruction class
  always_comb begin
    dec        = '0;
    is_mem     = 1'b0;
    is_rmw     = 1'b0;
    is_muldiv  = 1'b0;
    rmw_be_dec = 4'b0000;
    case (op)
      6'b000000: begin
        case (funct)
          6'b001000: begin dec.jump1 = 1'b1; dec.jump = 1'b1; end
          6'b001001: begin
            dec.regwrite = 1'b1; dec.regdst1 = 1'b1; dec.jump1 = 1'b1; dec.jump = 1'b1;
          end
          6'b010001, 6'b010011: dec.aluop = 2'b10;
          6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
            dec.aluop = 2'b10; is_muldiv = 1'b1;
          end
          default: begin dec.regwrite = 1'b1; dec.regdst1 = 1'b1; dec.aluop = 2'b10; end
        endcase
      end
      6'b000001: begin
        case (dest)
          5'b00000, 5'b00001: begin dec.branch = 1'b1; dec.aluop = 2'b01; end
          5'b10000, 5'b10001: begin
            dec.branch = 1'b1; dec.aluop = 2'b01; dec.regwrite = 1'b1; dec.regdst2 = 1'b1;
          end
          default: ;
        endcase
      end
      6'b000010: dec.jump = 1'b1;
      6'b000011: begin dec.jump = 1'b1; dec.regwrite = 1'b1; dec.regdst2 = 1'b1; end
      6'b000100, 6'b000101, 6'b000110, 6'b000111: begin dec.branch = 1'b1; dec.aluop = 2'b01; end
      6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b001100, 6'b001101, 6'b001110: begin
        dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.aluop = 2'b10;
      end
      6'b001111: begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.aluop = 2'b11; end
      6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101, 6'b100110: begin
        dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.data_read = 1'b1; dec.memtoreg1 = 1'b1;
        is_mem = 1'b1;
        case (op[2:0])
          3'b000:  dec.loadcontrol = 3'b000;
          3'b001:  dec.loadcontrol = 3'b010;
          3'b010:  dec.loadcontrol = 3'b110;
          3'b011:  dec.loadcontrol = 3'b101;
          3'b100:  dec.loadcontrol = 3'b001;
          3'b101:  dec.loadcontrol = 3'b011;
          default: dec.loadcontrol = 3'b111;
        endcase
      end
      6'b101011: begin
        dec.alusrc = 1'b1; dec.data_write = 1'b1; dec.byteenable = 4'b1111; is_mem = 1'b1;
      end
      6'b101000, 6'b101001: begin
        // SB/SH start by reading the word they will partially overwrite
        dec.alusrc = 1'b1; dec.data_read = 1'b1; is_rmw = 1'b1;
        if (op[0]) rmw_be_dec = addr_lo[1] ? 4'b1100 : 4'b0011;
        else       rmw_be_dec = 4'b0001 << addr_lo;
      end
      default: ;
    endcase
  end

  // Controls used during the RMW write phase
  always_comb begin
    wr_ctrl            = '0;
    wr_ctrl.alusrc     = 1'b1;
    wr_ctrl.data_write = 1'b1;
    wr_ctrl.byteenable = lat_be;
  end

  // Output select: live decode in DECODE, held registers elsewhere
  always_comb begin
    out   = '0;
    stall = 1'b0;
    if (!reset) begin
      case (cur)
        ST_DECODE: begin
          if (instr_valid) begin
            out = dec;
            if (trap) begin
              out.regwrite   = 1'b0;
              out.data_read  = 1'b0;
              out.data_write = 1'b0;
            end else if (is_mem) begin
              stall = mem_waitrequest;
            end else if (is_rmw || is_muldiv) begin
              stall = 1'b1;
            end
          end
        end
        ST_MEM_WAIT, ST_RMW_WR: begin
          out   = held;
          stall = mem_waitrequest && !wait_last;
        end
        // the read phase always stalls unless it is giving up on a timeout
        ST_RMW_RD: begin
          out   = held;
          stall = !(mem_waitrequest && wait_last);
        end
        ST_MULDIV: begin
          out   = held;
          stall = (md_cnt != 8'd0);
        end
        default: ;
      endcase
    end
  end

  // Sequencer: state, held controls, wait/busy counters, sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      cur      <= ST_DECODE;
      held     <= '0;
      wait_cnt <= '0;
      md_cnt   <= '0;
      lat_be   <= '0;
      err      <= 1'b0;
    end else begin
      case (cur)
        ST_DECODE: begin
          wait_cnt <= '0;
          if (instr_valid) begin
            if (trap) begin
              err <= 1'b1;
            end else if (is_mem && mem_waitrequest) begin
              held <= dec;
              cur  <= ST_MEM_WAIT;
            end else if (is_rmw) begin
              held   <= dec;
              lat_be <= rmw_be_dec;
              cur    <= ST_RMW_RD;
            end else if (is_muldiv) begin
              held   <= '0;
              md_cnt <= MD_LOAD;
              cur    <= ST_MULDIV;
            end
          end
        end
        ST_MEM_WAIT, ST_RMW_WR: begin
          if (!mem_waitrequest) begin
            held <= '0;
            cur  <= ST_DECODE;
          end else if (wait_last) begin
            err  <= 1'b1;
            held <= '0;
            cur  <= ST_DECODE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_RMW_RD: begin
          if (!mem_waitrequest) begin
            held     <= wr_ctrl;
            wait_cnt <= '0;
            cur      <= ST_RMW_WR;
          end else if (wait_last) begin
            err  <= 1'b1;
            held <= '0;
            cur  <= ST_DECODE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_MULDIV: begin
          if (md_cnt == 8'd0) cur <= ST_DECODE;
          else                md_cnt <= md_cnt - 8'd1;
        end
        default: begin
          held <= '0;
          cur  <= ST_DECODE;
        end
      endcase
    end
  end

  assign regwrite    = out.regwrite;
  assign regdst2     = out.regdst2;
  assign regdst1     = out.regdst1;
  assign alusrc      = out.alusrc;
  assign branch      = out.branch;
  assign data_read   = out.data_read;
  assign data_write  = out.data_write;
  assign memtoreg1   = out.memtoreg1;
  assign jump1       = out.jump1;
  assign jump        = out.jump;
  assign aluop       = out.aluop;
  assign loadcontrol = out.loadcontrol;
  assign byteenable  = out.byteenable;
  assign state       = STATE_W'(cur);

endmodule

// File: tb/tb_mips_cpu_control_seq.sv
// Bench for mips_cpu_control_seq: directed steps plus randomized instructions,
// each expanded by a reference model into a per-cycle expected timeline.
module tb_mips_cpu_control_seq;

  localparam int MD  = 4;
  localparam int MAX = 15;
`ifdef UNALIGNED_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [2:0] S_DEC = 3'd0, S_MW = 3'd1, S_RD = 3'd2, S_WR = 3'd3, S_MD = 3'd4;

  logic       clk = 1'b0;
  logic       reset, instr_valid, mem_waitrequest;
  logic [5:0] op, funct;
  logic [4:0] dest;
  logic [1:0] addr_lo;
  logic       regwrite, regdst2, regdst1, alusrc, branch, data_read, data_write;
  logic       memtoreg1, jump1, jump, stall, err;
  logic [1:0] aluop;
  logic [2:0] loadcontrol;
  logic [3:0] byteenable;
  logic [2:0] state;
  logic [18:0] ctrl_bus;

  int tests_run = 0;
  int fails     = 0;
  logic m_err   = 1'b0;

  typedef struct packed {
    logic        drive;   // inputs fixed by the step (else randomized, must be ignored)
    logic        iv;
    logic        wr;
    logic [2:0]  st;
    logic        stall;
    logic [18:0] ctrl;
    logic        err;
  } step_t;
  step_t exp_q[$];

  logic [5:0] op_pool [29] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7,
                               6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15,
                               6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38,
                               6'd43, 6'd40, 6'd41, 6'd39, 6'd63, 6'd16};
  logic [5:0] funct_pool [14] = '{6'd33, 6'd35, 6'd36, 6'd37, 6'd42, 6'd8, 6'd9,
                                  6'd17, 6'd19, 6'd24, 6'd25, 6'd26, 6'd27, 6'd0};
  logic [4:0] dest_pool [6] = '{5'd0, 5'd1, 5'd16, 5'd17, 5'd2, 5'd31};

  mips_cpu_control_seq #(.MULDIV_CYCLES(MD), .MEM_WAIT_MAX(MAX), .STATE_W(3)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .op(op), .funct(funct),
    .dest(dest), .addr_lo(addr_lo), .mem_waitrequest(mem_waitrequest),
    .regwrite(regwrite), .regdst2(regdst2), .regdst1(regdst1), .alusrc(alusrc),
    .branch(branch), .data_read(data_read), .data_write(data_write),
    .memtoreg1(memtoreg1), .jump1(jump1), .jump(jump), .aluop(aluop),
    .loadcontrol(loadcontrol), .byteenable(byteenable), .stall(stall), .err(err),
    .state(state)
  );

  assign ctrl_bus = {regwrite, regdst2, regdst1, alusrc, branch, data_read, data_write,
                     memtoreg1, jump1, jump, aluop, loadcontrol, byteenable};

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- reference model ----------------
  // Control word per instruction, written as the decode table:
  // {regwrite,regdst2,regdst1,alusrc,branch,data_read,data_write,memtoreg1,jump1,jump,aluop}
  function automatic logic [18:0] ref_ctrl(input logic [5:0] o, input logic [5:0] f,
                                           input logic [4:0] d);
    logic [11:0] c;
    logic [2:0]  lc;
    logic [3:0]  be;
    int oi, fi, di;
    oi = int'(o); fi = int'(f); di = int'(d);
    c = 12'b0; lc = 3'b000; be = 4'b0000;
    if (oi == 0) begin
      if (fi == 8)                                         c = 12'b000000001100;
      else if (fi == 9)                                    c = 12'b101000001100;
      else if (fi == 17 || fi == 19 || (fi >= 24 && fi <= 27)) c = 12'b000000000010;
      else                                                 c = 12'b101000000010;
    end else if (oi == 1) begin
      if (di == 0 || di == 1)        c = 12'b000010000001;
      else if (di == 16 || di == 17) c = 12'b110010000001;
    end
    else if (oi == 2)              c = 12'b000000000100;
    else if (oi == 3)              c = 12'b110000000100;
    else if (oi >= 4 && oi <= 7)   c = 12'b000010000001;
    else if (oi >= 8 && oi <= 14)  c = 12'b100100000010;
    else if (oi == 15)             c = 12'b100100000011;
    else if (oi >= 32 && oi <= 38) begin
      c = 12'b100101010000;
      case (oi)
        32: lc = 3'b000;  // LB
        33: lc = 3'b010;  // LH
        34: lc = 3'b110;  // LWL
        35: lc = 3'b101;  // LW
        36: lc = 3'b001;  // LBU
        37: lc = 3'b011;  // LHU
        default: lc = 3'b111;  // LWR
      endcase
    end
    else if (oi == 43)             begin c = 12'b000100100000; be = 4'b1111; end
    else if (oi == 40 || oi == 41) c = 12'b000101000000;
    return {c, lc, be};
  endfunction

  // 0 single-cycle, 1 load/SW, 2 SB/SH, 3 mult/div
  function automatic int ref_kind(input logic [5:0] o, input logic [5:0] f);
    int oi, fi;
    oi = int'(o); fi = int'(f);
    if ((oi >= 32 && oi <= 38) || oi == 43) return 1;
    if (oi == 40 || oi == 41) return 2;
    if (oi == 0 && fi >= 24 && fi <= 27) return 3;
    return 0;
  endfunction

  function automatic logic ref_misaligned(input logic [5:0] o, input logic [1:0] a);
    int oi;
    oi = int'(o);
    if (oi == 35 || oi == 43) return TRAP_EN && (a != 2'b00);
    if (oi == 33 || oi == 37 || oi == 41) return TRAP_EN && a[0];
    return 1'b0;
  endfunction

  function automatic void push(input logic drv, input logic iv, input logic wr,
                               input logic [2:0] st, input logic stl, input logic [18:0] c);
    step_t s;
    s.drive = drv; s.iv = iv; s.wr = wr; s.st = st; s.stall = stl; s.ctrl = c; s.err = m_err;
    exp_q.push_back(s);
  endfunction

  // One memory state: 'waits' high cycles then a low one, or a timeout after MAX.
  function automatic bit mem_phase(input logic [2:0] st, input logic [18:0] c,
                                   input int waits, input logic done_stall);
    if (waits >= MAX) begin
      for (int i = 0; i < MAX; i++) push(1'b0, 1'b0, 1'b1, st, (i != MAX - 1), c);
      m_err = 1'b1;
      return 1'b1;
    end
    for (int i = 0; i < waits; i++) push(1'b0, 1'b0, 1'b1, st, 1'b1, c);
    push(1'b0, 1'b0, 1'b0, st, done_stall, c);
    return 1'b0;
  endfunction

  // ---------------- driver ----------------
  task automatic drain(input string name, input logic [5:0] o, input logic [5:0] f,
                       input logic [4:0] d, input logic [1:0] a);
    step_t s;
    while (exp_q.size() != 0) begin
      s = exp_q.pop_front();
      if (s.drive) begin
        instr_valid = s.iv; op = o; funct = f; dest = d; addr_lo = a;
      end else begin
        instr_valid = 1'($urandom_range(0, 1));
        op = 6'($urandom); funct = 6'($urandom); dest = 5'($urandom); addr_lo = 2'($urandom);
      end
      mem_waitrequest = s.wr;
      @(negedge clk);
      check({name, "/state"}, 32'(state), 32'(s.st));
      check({name, "/stall"}, 32'(stall), 32'(s.stall));
      check({name, "/ctrl"},  32'(ctrl_bus), 32'(s.ctrl));
      check({name, "/err"},   32'(err), 32'(s.err));
      @(posedge clk); #1;
    end
  endtask

  task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                           input logic [4:0] d, input logic [1:0] a, input int w1, input int w2);
    logic [18:0] c, cw;
    logic [3:0]  be;
    bit          to;
    c = ref_ctrl(o, f, d);
    if (ref_misaligned(o, a)) begin
      c[18] = 1'b0; c[13] = 1'b0; c[12] = 1'b0;
      push(1'b1, 1'b1, 1'($urandom_range(0, 1)), S_DEC, 1'b0, c);
      m_err = 1'b1;
    end else begin
      case (ref_kind(o, f))
        1: begin
          if (w1 == 0) push(1'b1, 1'b1, 1'b0, S_DEC, 1'b0, c);
          else begin
            push(1'b1, 1'b1, 1'b1, S_DEC, 1'b1, c);
            to = mem_phase(S_MW, c, w1 - 1, 1'b0);
          end
        end
        2: begin
          be = (o == 6'd40) ? 4'(4'b0001 << a) : (a[1] ? 4'b1100 : 4'b0011);
          cw = {12'b000100100000, 3'b000, be};
          push(1'b1, 1'b1, 1'($urandom_range(0, 1)), S_DEC, 1'b1, c);
          to = mem_phase(S_RD, c, w1, 1'b1);
          if (!to) to = mem_phase(S_WR, cw, w2, 1'b0);
        end
        3: begin
          push(1'b1, 1'b1, 1'($urandom_range(0, 1)), S_DEC, 1'b1, c);
          for (int i = 0; i < MD; i++)
            push(1'b0, 1'b0, 1'($urandom_range(0, 1)), S_MD, (i != MD - 1), 19'd0);
        end
        default: push(1'b1, 1'b1, 1'($urandom_range(0, 1)), S_DEC, 1'b0, c);
      endcase
    end
    drain(name, o, f, d, a);
  endtask

  task automatic idle_cycle();
    push(1'b1, 1'b0, 1'($urandom_range(0, 1)), S_DEC, 1'b0, 19'd0);
    drain("idle", 6'($urandom), 6'($urandom), 5'($urandom), 2'($urandom));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; instr_valid = 1'b0; mem_waitrequest = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("reset/ctrl", 32'(ctrl_bus), 32'd0);
      check("reset/stall", 32'(stall), 32'd0);
      if (i > 0) begin
        check("reset/state", 32'(state), 32'(S_DEC));
        check("reset/err", 32'(err), 32'd0);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    m_err = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [5:0] o, f;
    logic [4:0] d;
    logic [1:0] a;
    int w1, w2;

    reset = 1'b1; instr_valid = 1'b0; op = '0; funct = '0; dest = '0; addr_lo = '0;
    mem_waitrequest = 1'b0;
    @(posedge clk); #1;
    do_reset(2);
    idle_cycle();

    run_instr("addiu", 6'b001001, 6'd0, 5'd0, 2'b00, 0, 0);
    run_instr("lw_wait3", 6'b100011, 6'd0, 5'd0, 2'b00, 3, 0);
    run_instr("sb_a10", 6'b101000, 6'd0, 5'd0, 2'b10, 0, 0);
    run_instr("sh_a10_waits", 6'b101001, 6'd0, 5'd0, 2'b10, 2, 1);
    run_instr("mult", 6'b000000, 6'b011000, 5'd0, 2'b00, 0, 0);
    run_instr("bltzal", 6'b000001, 6'd0, 5'd16, 2'b00, 0, 0);
    run_instr("undef_op", 6'b111111, 6'd0, 5'd0, 2'b00, 0, 0);

    // timeout on a stuck memory, then err must stay set until reset
    run_instr("lw_timeout", 6'b100011, 6'd0, 5'd0, 2'b00, 40, 0);
    run_instr("after_to", 6'b001001, 6'd0, 5'd0, 2'b00, 0, 0);
    idle_cycle();
    run_instr("sb_rd_timeout", 6'b101000, 6'd0, 5'd0, 2'b01, 30, 0);
    do_reset(1);
    idle_cycle();

    // reset while in the RMW read phase: no write may follow
    instr_valid = 1'b1; op = 6'b101000; funct = '0; dest = '0; addr_lo = 2'b01;
    mem_waitrequest = 1'b0;
    @(negedge clk);
    check("rmw_abort/dec_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    instr_valid = 1'b0; mem_waitrequest = 1'b1;
    @(negedge clk);
    check("rmw_abort/rd_state", 32'(state), 32'(S_RD));
    check("rmw_abort/rd_write", 32'(data_write), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rmw_abort/rst_ctrl", 32'(ctrl_bus), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; mem_waitrequest = 1'b0;
    m_err = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rmw_abort/state", 32'(state), 32'(S_DEC));
      check("rmw_abort/ctrl", 32'(ctrl_bus), 32'd0);
      check("rmw_abort/stall", 32'(stall), 32'd0);
      check("rmw_abort/err", 32'(err), 32'd0);
      @(posedge clk); #1;
    end

    // misaligned SW: trapped only when the alignment check is built in
    run_instr("sw_a01", 6'b101011, 6'd0, 5'd0, 2'b01, 0, 0);
    do_reset(1);

    for (int n = 0; n < 250; n++) begin
      o  = op_pool[$urandom_range(0, 28)];
      f  = funct_pool[$urandom_range(0, 13)];
      d  = dest_pool[$urandom_range(0, 5)];
      a  = 2'($urandom);
      w1 = ($urandom_range(0, 15) == 0) ? 20 : int'($urandom_range(0, 3));
      w2 = ($urandom_range(0, 15) == 0) ? 20 : int'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) idle_cycle();
      if ($urandom_range(0, 39) == 0) do_reset(1);
      run_instr("rand", o, f, d, a, w1, w2);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
